// File: rtl/shift_arb_seq.sv
// Round-robin arbiter and pass sequencer in front of a shared 16-bit arithmetic right-shifter.
// Amounts above MAX_STEP are split into several registered passes through the external shifter.
module shift_arb_seq #(
  parameter int WIDTH    = 16,
  parameter int AMT_W    = 5,
  parameter int MAX_STEP = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [AMT_W-1:0] req0_amt,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             req1_ready,
  output logic [WIDTH-1:0] sh_a,
  output logic [3:0]       sh_op,
  input  logic [WIDTH-1:0] sh_r,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   work_reg, work_next;
  logic [AMT_W-1:0]   rem_reg, rem_next;
  logic               id_reg, id_next;
  logic               ptr_reg, ptr_next;

  logic [1:0]         valid_vec;
  logic [1:0]         grant;
  logic [1:0]         ready_vec;
  logic [3:0]         step;
  logic               last_pass;

  assign valid_vec = {req1_valid, req0_valid};

  // A lone requester always wins; on contention the pointer decides.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      assign grant[gi]     = valid_vec[gi] & (~valid_vec[1-gi] | (ptr_reg == 1'(gi)));
      assign ready_vec[gi] = (state_reg == IDLE) & grant[gi];
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  assign last_pass = (rem_reg <= AMT_W'(MAX_STEP));
  assign step      = last_pass ? rem_reg[3:0] : 4'(MAX_STEP);

  assign sh_a      = work_reg;
  assign sh_op     = (state_reg == RUN) ? step : 4'd0;
  assign rsp_valid = (state_reg == DONE);
  assign rsp_data  = (state_reg == DONE) ? work_reg : '0;
  assign rsp_id    = (state_reg == DONE) ? id_reg : 1'b0;
  assign busy      = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    rem_next   = rem_reg;
    id_next    = id_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|ready_vec) begin
          work_next  = ready_vec[1] ? req1_a : req0_a;
          rem_next   = ready_vec[1] ? req1_amt : req0_amt;
          id_next    = ready_vec[1];
          state_next = RUN;
        end
      end
      RUN: begin
        work_next = sh_r;
        rem_next  = rem_reg - AMT_W'(step);
        if (last_pass) state_next = DONE;
      end
      DONE: begin
        // Served requester drops to lowest priority once the result is taken.
        if (rsp_ready) begin
          ptr_next   = ~id_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      rem_reg   <= '0;
      id_reg    <= 1'b0;
      ptr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      rem_reg   <= rem_next;
      id_reg    <= id_next;
      ptr_reg   <= ptr_next;
    end
  end

endmodule

// File: doc/shift_arb_seq.md
Name: shift_arb_seq

Overview:
Sequencer and arbiter for the shared 16-bit arithmetic right-shift mux (one pass = shift by 0..15 under a 4-bit OP).
- Two requesters submit (operand, 5-bit amount 0..31). The block arbitrates between them round-robin.
- It decomposes amounts above 15 into multiple registered passes through the external shifter and returns the result on a valid/ready response channel.
- It sits between the ALU issue logic and the combinational shifter.

Parameters:
WIDTH, 16, operand/result width; fixed to match the shifter.
AMT_W, 5, shift-amount width; amounts 0..2^AMT_W-1.
MAX_STEP, 15, largest per-pass shift the shifter supports.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req0_valid  in  1  requester 0 has a request.
req0_a  in  WIDTH  requester 0 operand.
req0_amt  in  AMT_W  requester 0 shift amount.
req0_ready  out  1  requester 0 accepted this cycle (valid&ready).
req1_valid, req1_a, req1_amt, req1_ready: same as requester 0, for requester 1.
sh_a  out  WIDTH  operand to shifter (= work register).
sh_op  out  4  shift amount to shifter for current pass.
sh_r  in  WIDTH  combinational shifter result.
rsp_valid  out  1  result available.
rsp_data  out  WIDTH  shifted result.
rsp_id  out  1  requester that owns rsp_data.
rsp_ready  in  1  consumer accepts response.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, work=0, rem=0, id=0, priority pointer=req0.
  - All outputs 0.
  - An in-flight operation is discarded; no response is ever issued for it.
- States IDLE, RUN, DONE.
- IDLE:
  - reqN_ready = reqN_valid & grant(N), combinational, at most one high.
  - Grant: if only one requester is valid, grant it. If both are valid, grant the pointer's requester.
  - On accept edge: work<=reqN_a, rem<=reqN_amt, id<=N; go to RUN.
  - A valid dropped before acceptance is legal; nothing is latched.
- RUN, one pass per cycle:
  - step = min(rem, MAX_STEP); sh_a=work; sh_op=step.
  - At the edge: work<=sh_r, rem<=rem-step.
  - If rem<=MAX_STEP (final pass, including rem=0, which is a single pass with op 0), go to DONE.
- Passes = max(1, ceil(amt/15)): amt 0..15 takes 1, 16..30 takes 2, 31 takes 3.
- DONE:
  - rsp_valid=1, rsp_data=work, rsp_id=id, all held stable until rsp_ready.
  - On the rsp_valid&rsp_ready edge: go to IDLE; pointer <= the other requester (served requester drops to lowest priority).
  - No new request is accepted while in RUN or DONE (reqN_ready=0).
- sh_op=0 outside RUN; sh_a always reflects work.
- Latency: accept at edge T; rsp_valid rises after edge T+passes; minimum is 1 cycle after acceptance.
- Next acceptance is possible in the cycle after the response handshake (one-cycle IDLE bubble).
- Arithmetic: every pass is sign-extending, so any amt>=15 yields all copies of bit 15 (0x0000 or 0xFFFF).

Test Plan:
- Reset, then req0 a=0x8000 amt=4 -> req0_ready same cycle; rsp_valid one cycle after accept; rsp_data=0xF800, rsp_id=0; sh_op=4 during RUN.
- req1 a=0x4000 amt=14 -> 0x0001 after 1 pass. Same operand amt=16 -> sh_op sequence 15,1; rsp_data=0x0000; rsp_valid 2 cycles after accept.
- req0 a=0x9000 amt=31 -> sh_op 15,15,1; rsp_data=0xFFFF; rsp_valid 3 cycles after accept. Same operand amt=0 -> rsp_data=0x9000 after 1 pass with sh_op=0.
- Both valid continuously after reset with rsp_ready=1 -> grants alternate req0, req1, req0; rsp_id matches each grant. No request is accepted while busy=1.
- rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_data and rsp_id stay stable; req0_ready and req1_ready stay 0. Raising rsp_ready completes the handshake and returns the block to IDLE.
- rst_n pulsed low mid-RUN on an amt=31 op -> outputs 0 immediately; no rsp_valid afterwards; the next request is granted to req0.
